// File: rtl/instruction_decode_cc.sv
// RV32I decode stage: register file with write-through bypass, control/ALU decode,
// immediate extension, and the ID/EX pipeline register feeding execute.
module instruction_decode_cc #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       InstrD,
    input  logic [DATA_W-1:0] PCD,
    input  logic              RegWriteW,
    input  logic [4:0]        RdW,
    input  logic [DATA_W-1:0] ResultW,
    input  logic              FlushE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic [1:0]        ResultSrcE,
    output logic [2:0]        ALUControlE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] ImmExtE,
    output logic [DATA_W-1:0] PCE,
    output logic [DATA_W-1:0] PCPlus4E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_sel_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic              alu_src;
        logic [1:0]        result_src;
        logic [2:0]        alu_control;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm_ext;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pc_plus4;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
    } idex_t;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [4:0]        rs1, rs2, rd;
    imm_sel_t          imm_sel;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rd1, rd2;
    logic [DATA_W-1:0] regs [NREGS];
    idex_t             dec, ex;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];
    assign rd     = InstrD[11:7];

    always_comb begin
        dec         = '0;
        imm_sel     = IMM_NONE;
        unique case (opcode)
            OP_LW: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
                imm_sel        = IMM_I;
            end
            OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_sel       = IMM_S;
            end
            OP_R: dec.reg_write = 1'b1;
            OP_IALU: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_sel       = IMM_I;
            end
            OP_BEQ: begin
                dec.branch      = 1'b1;
                dec.alu_control = ALU_SUB;
                imm_sel         = IMM_B;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = 2'b10;
                imm_sel        = IMM_J;
            end
            default: ;
        endcase

        // Only arithmetic ops look at funct3/funct7; sub needs op[5] so addi never becomes sub.
        if (opcode == OP_R || opcode == OP_IALU) begin
            unique case (funct3)
                3'b000:  dec.alu_control = (opcode[5] & InstrD[30]) ? ALU_SUB : ALU_ADD;
                3'b010:  dec.alu_control = ALU_SLT;
                3'b110:  dec.alu_control = ALU_OR;
                3'b111:  dec.alu_control = ALU_AND;
                default: dec.alu_control = ALU_ADD;
            endcase
        end

        dec.rd1      = rd1;
        dec.rd2      = rd2;
        dec.imm_ext  = imm_ext;
        dec.pc       = PCD;
        dec.pc_plus4 = PCD + 32'd4;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = rd;
    end

    always_comb begin
        imm_ext = '0;
        unique case (imm_sel)
            IMM_I:   imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S:   imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J:   imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    // Write-through: a same-cycle WB write to the register being read wins over the array.
    always_comb begin
        rd1 = regs[rs1];
        rd2 = regs[rs2];
        if (RegWriteW && RdW != 5'd0 && RdW == rs1) rd1 = ResultW;
        if (RegWriteW && RdW != 5'd0 && RdW == rs2) rd2 = ResultW;
        if (rs1 == 5'd0) rd1 = '0;
        if (rs2 == 5'd0) rd2 = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (RegWriteW && RdW != 5'd0) begin
            regs[RdW] <= ResultW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         ex <= '0;
        else if (FlushE) ex <= '0;
        else             ex <= dec;
    end

    assign RegWriteE   = ex.reg_write;
    assign MemWriteE   = ex.mem_write;
    assign JumpE       = ex.jump;
    assign BranchE     = ex.branch;
    assign ALUSrcE     = ex.alu_src;
    assign ResultSrcE  = ex.result_src;
    assign ALUControlE = ex.alu_control;
    assign RD1E        = ex.rd1;
    assign RD2E        = ex.rd2;
    assign ImmExtE     = ex.imm_ext;
    assign PCE         = ex.pc;
    assign PCPlus4E    = ex.pc_plus4;
    assign Rs1E        = ex.rs1;
    assign Rs2E        = ex.rs2;
    assign RdE         = ex.rd;

endmodule
